// File: rtl/bicubic_upsample_px.sv
// bicubic_upsample_px: 4x separable bicubic upsampler, multi-channel.
// Takes one 4x4 source window per input handshake. For each output row it runs
// a vertical 4-tap pass into a full-precision tmp register. It then produces
// the 4 output pixels of that row combinationally from tmp, with a horizontal
// 4-tap pass, half-up rounding and clamping. A nearest-neighbour bypass
// replicates P[1][1] to every output pixel.
module bicubic_upsample_px #(
    parameter int CHANNEL_WIDTH = 8,
    parameter int CHANNELS      = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_mode,
    input  logic [16*CHANNELS*CHANNEL_WIDTH-1:0] in_pix,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [4*CHANNELS*CHANNEL_WIDTH-1:0]  out_pix,
    output logic [1:0]                           out_row,
    output logic                                 out_last
);

    localparam int CW    = CHANNEL_WIDTH;
    localparam int T_W   = CW + 9;   // vertical partial sums
    localparam int S_W   = CW + 18;  // horizontal full sums
    localparam int PIX_W = 16 * CHANNELS * CW;
    localparam int OUT_W = 4 * CHANNELS * CW;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_VERT = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic signed [S_W-1:0] ROUND_HALF = S_W'(8192);
    localparam logic signed [S_W-1:0] PIX_MAX    = S_W'((1 << CW) - 1);

    // Kernel weights in units of 1/128, indexed by output phase and source tap.
    function automatic logic signed [8:0] weight(input logic [1:0] phase, input logic [1:0] tap);
        logic signed [8:0] w;
        case ({phase, tap})
            4'b00_01: w = 9'sd128;
            4'b01_00: w = -9'sd9;
            4'b01_01: w = 9'sd111;
            4'b01_10: w = 9'sd29;
            4'b01_11: w = -9'sd3;
            4'b10_00: w = -9'sd8;
            4'b10_01: w = 9'sd72;
            4'b10_10: w = 9'sd72;
            4'b10_11: w = -9'sd8;
            4'b11_00: w = -9'sd3;
            4'b11_01: w = 9'sd29;
            4'b11_10: w = 9'sd111;
            4'b11_11: w = -9'sd9;
            default:  w = 9'sd0;
        endcase
        return w;
    endfunction

    logic [1:0]             state;
    logic [1:0]             row;
    logic [PIX_W-1:0]       win_pix;
    logic                   win_mode;
    logic signed [T_W-1:0]  tmp  [4][CHANNELS];
    logic signed [T_W-1:0]  vert [4][CHANNELS];
    logic [OUT_W-1:0]       pix_calc;
    logic                   in_fire;

    assign in_ready = (state == ST_IDLE) ||
                      ((state == ST_OUT) && (row == 2'd3) && out_ready);
    assign in_fire  = in_valid && in_ready;

    assign out_valid = (state == ST_OUT);
    assign out_pix   = out_valid ? pix_calc : '0;
    assign out_row   = out_valid ? row : 2'd0;
    assign out_last  = out_valid && (row == 2'd3);

    // Control FSM: accept window, alternate VERT/OUT per row, chain on last beat.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= ST_IDLE;
            row   <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_fire) begin
                        state <= ST_VERT;
                        row   <= 2'd0;
                    end
                end
                ST_VERT: state <= ST_OUT;
                ST_OUT: begin
                    if (out_ready) begin
                        if (row != 2'd3) begin
                            row   <= row + 2'd1;
                            state <= ST_VERT;
                        end else if (in_valid) begin
                            row   <= 2'd0;
                            state <= ST_VERT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Window capture on input handshake.
    always_ff @(posedge clk) begin
        // NOTE: datapath storage has no reset; the FSM guarantees it is written
        // before it is ever observed, so resetting it would only cost area.
        if (in_fire) begin
            win_pix  <= in_pix;
            win_mode <= in_mode;
        end
    end

    // Vertical pass: T_r[j] = sum_i W[r][i] * P[i][j], full precision.
    always_comb begin
        // NOTE: every combinational output gets a value on every path (here by
        // full loop coverage) so no latch is inferred.
        for (int j = 0; j < 4; j++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                logic signed [T_W-1:0] acc;
                acc = '0;
                for (int i = 0; i < 4; i++) begin
                    acc = acc + T_W'(weight(row, 2'(i))) *
                          T_W'($signed({1'b0, win_pix[((4*i+j)*CHANNELS+c)*CW +: CW]}));
                end
                vert[j][c] = acc;
            end
        end
    end

    // Load tmp with the current row's vertical result.
    always_ff @(posedge clk) begin
        if (state == ST_VERT) begin
            tmp <= vert;
        end
    end

    // Horizontal pass, rounding, clamping and nearest bypass for the current row.
    always_comb begin
        pix_calc = '0;
        for (int j = 0; j < 4; j++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                logic signed [S_W-1:0] s;
                logic signed [S_W-1:0] rnd;
                logic [CW-1:0]         px;
                s = '0;
                for (int jj = 0; jj < 4; jj++) begin
                    s = s + S_W'(weight(2'(j), 2'(jj))) * S_W'(tmp[jj][c]);
                end
                rnd = (s + ROUND_HALF) >>> 14;
                if (rnd[S_W-1]) begin
                    px = '0;
                end else if (rnd > PIX_MAX) begin
                    px = '1;
                end else begin
                    px = rnd[CW-1:0];
                end
                if (win_mode) begin
                    px = win_pix[(5*CHANNELS+c)*CW +: CW];
                end
                pix_calc[(j*CHANNELS+c)*CW +: CW] = px;
            end
        end
    end

endmodule

// File: tb/tb_bicubic_upsample_px.sv
// Directed self-checking bench for bicubic_upsample_px (CHANNEL_WIDTH=8, CHANNELS=3).
// Expected pixels are hand-derived from the kernel table: for windows constant
// along one axis the other pass is exact, so O = floor(dot(W, v)/128 + 0.5), clamped.
module tb_bicubic_upsample_px;

    localparam int CW    = 8;
    localparam int CH    = 3;
    localparam int PIX_W = 16 * CH * CW;
    localparam int OUT_W = 4 * CH * CW;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [PIX_W-1:0] in_pix;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_pix;
    logic [1:0]       out_row;
    logic             out_last;

    int n_cmp = 0;
    int n_err = 0;

    logic [CW-1:0] src  [4][4][CH];
    logic [CW-1:0] expv [4][4][CH];
    logic [PIX_W-1:0] b_pix;

    always #5 clk = ~clk;

    bicubic_upsample_px #(.CHANNEL_WIDTH(CW), .CHANNELS(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_pix    (in_pix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .out_row   (out_row),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PIX_W-1:0] pack_win();
        logic [PIX_W-1:0] v;
        v = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int c = 0; c < CH; c++)
                    v[((4*i+j)*CH+c)*CW +: CW] = src[i][j][c];
        return v;
    endfunction

    function automatic logic [OUT_W-1:0] exp_row(input int r);
        logic [OUT_W-1:0] v;
        v = '0;
        for (int j = 0; j < 4; j++)
            for (int c = 0; c < CH; c++)
                v[(j*CH+c)*CW +: CW] = expv[r][j][c];
        return v;
    endfunction

    // Every row holds columns p0..p3; every output row expects e0..e3.
    task automatic cols(input int ch, input logic [7:0] p0, p1, p2, p3, e0, e1, e2, e3);
        logic [7:0] p [4];
        logic [7:0] e [4];
        p = '{p0, p1, p2, p3};
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                src[i][j][ch]  = p[j];
                expv[i][j][ch] = e[j];
            end
    endtask

    // Source row i is constant p_i; output row r is constant e_r.
    task automatic rows(input int ch, input logic [7:0] p0, p1, p2, p3, e0, e1, e2, e3);
        logic [7:0] p [4];
        logic [7:0] e [4];
        p = '{p0, p1, p2, p3};
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                src[i][j][ch]  = p[i];
                expv[i][j][ch] = e[i];
            end
    endtask

    task automatic send_window(input logic mode);
        @(negedge clk);
        in_pix   = pack_win();
        in_mode  = mode;
        in_valid = 1'b1;
        #1 check("accept_ready", OUT_W'(in_ready), OUT_W'(1));
        @(negedge clk);
        in_valid = 1'b0;
        in_mode  = ~mode;
        for (int k = 0; k < PIX_W / 32; k++) in_pix[k*32 +: 32] = $urandom;
        check("vert_no_valid", OUT_W'(out_valid), OUT_W'(0));
        check("vert_busy_ready", OUT_W'(in_ready), OUT_W'(0));
    endtask

    task automatic get_beats(input int stall_row, input int stall_n, input int abort_row,
                             input bit chain, input logic [PIX_W-1:0] nxt_pix, input logic nxt_mode);
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            check($sformatf("r%0d_valid", r), OUT_W'(out_valid), OUT_W'(1));
            check($sformatf("r%0d_row", r), OUT_W'(out_row), OUT_W'(r));
            check($sformatf("r%0d_last", r), OUT_W'(out_last), OUT_W'(r == 3));
            check($sformatf("r%0d_pix", r), out_pix, exp_row(r));
            if (r < 3) check($sformatf("r%0d_busy_ready", r), OUT_W'(in_ready), OUT_W'(0));
            if (r == abort_row) begin
                #2 rst = 1'b1;
                #1;
                check("rst_valid", OUT_W'(out_valid), OUT_W'(0));
                check("rst_ready", OUT_W'(in_ready), OUT_W'(1));
                check("rst_pix", out_pix, OUT_W'(0));
                check("rst_row", OUT_W'(out_row), OUT_W'(0));
                check("rst_last", OUT_W'(out_last), OUT_W'(0));
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (r == stall_row) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                repeat (stall_n) begin
                    @(negedge clk);
                    check("stall_valid", OUT_W'(out_valid), OUT_W'(1));
                    check("stall_row", OUT_W'(out_row), OUT_W'(r));
                    check("stall_pix", out_pix, exp_row(r));
                    check("stall_ready", OUT_W'(in_ready), OUT_W'(0));
                end
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            if (r == 3 && chain) begin
                in_pix   = nxt_pix;
                in_mode  = nxt_mode;
                in_valid = 1'b1;
                #1 check("chain_ready", OUT_W'(in_ready), OUT_W'(1));
                @(negedge clk);
                in_valid = 1'b0;
                check("chain_vert", OUT_W'(out_valid), OUT_W'(0));
            end else begin
                @(negedge clk);
                check($sformatf("r%0d_gap", r), OUT_W'(out_valid), OUT_W'(0));
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_pix    = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("reset_ready", OUT_W'(in_ready), OUT_W'(1));
        check("reset_valid", OUT_W'(out_valid), OUT_W'(0));
        check("reset_pix", out_pix, OUT_W'(0));
        check("reset_row", OUT_W'(out_row), OUT_W'(0));
        check("reset_last", OUT_W'(out_last), OUT_W'(0));
        rst = 1'b0;

        // Flat window: everything stays 100
        for (int c = 0; c < CH; c++) cols(c, 100, 100, 100, 100, 100, 100, 100, 100);
        send_window(1'b0);
        get_beats(-1, 0, -1, 1'b0, '0, 1'b0);

        // Edge columns (0,0,255,255): 0, 52, 128, 203 in every row
        for (int c = 0; c < CH; c++) cols(c, 0, 0, 255, 255, 0, 52, 128, 203);
        send_window(1'b0);
        get_beats(-1, 0, -1, 1'b0, '0, 1'b0);

        // Clamp high, non-saturated mix, clamp low, one per channel
        cols(0, 0, 255, 255, 0, 255, 255, 255, 255);
        cols(1, 100, 200, 50, 0, 200, 178, 134, 86);
        cols(2, 255, 0, 0, 0, 0, 0, 0, 0);
        send_window(1'b0);
        get_beats(-1, 0, -1, 1'b0, '0, 1'b0);

        // Vertical-only variation: exercises the row phase selection
        rows(0, 0, 0, 255, 255, 0, 52, 128, 203);
        rows(1, 100, 200, 50, 0, 200, 178, 134, 86);
        rows(2, 77, 77, 77, 77, 77, 77, 77, 77);
        send_window(1'b0);
        get_beats(-1, 0, -1, 1'b0, '0, 1'b0);

        // Nearest mode with random surroundings
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int c = 0; c < CH; c++) begin
                    src[i][j][c]  = 8'($urandom_range(0, 255));
                    expv[i][j][c] = 8'(10 * (c + 1));
                end
        src[1][1][0] = 8'd10;
        src[1][1][1] = 8'd20;
        src[1][1][2] = 8'd30;
        send_window(1'b1);
        get_beats(-1, 0, -1, 1'b0, '0, 1'b0);

        // Backpressure: row 1 stalled for 5 cycles, busy in_valid ignored
        for (int c = 0; c < CH; c++) cols(c, 0, 0, 255, 255, 0, 52, 128, 203);
        send_window(1'b0);
        get_beats(1, 5, -1, 1'b0, '0, 1'b0);

        // Back-to-back: second window accepted on the row 3 handshake
        rows(0, 0, 0, 255, 255, 0, 52, 128, 203);
        rows(1, 100, 200, 50, 0, 200, 178, 134, 86);
        rows(2, 77, 77, 77, 77, 77, 77, 77, 77);
        b_pix = pack_win();
        for (int c = 0; c < CH; c++) cols(c, 0, 0, 255, 255, 0, 52, 128, 203);
        send_window(1'b0);
        get_beats(-1, 0, -1, 1'b1, b_pix, 1'b0);
        rows(0, 0, 0, 255, 255, 0, 52, 128, 203);
        rows(1, 100, 200, 50, 0, 200, 178, 134, 86);
        rows(2, 77, 77, 77, 77, 77, 77, 77, 77);
        get_beats(-1, 0, -1, 1'b0, '0, 1'b0);

        // Reset during row 2, then no stray beats, then a clean window
        for (int c = 0; c < CH; c++) cols(c, 0, 0, 255, 255, 0, 52, 128, 203);
        send_window(1'b0);
        get_beats(-1, 0, 2, 1'b0, '0, 1'b0);
        repeat (4) begin
            @(negedge clk);
            check("post_rst_idle", OUT_W'(out_valid), OUT_W'(0));
            check("post_rst_ready", OUT_W'(in_ready), OUT_W'(1));
        end
        rows(0, 0, 0, 255, 255, 0, 52, 128, 203);
        rows(1, 100, 200, 50, 0, 200, 178, 134, 86);
        rows(2, 77, 77, 77, 77, 77, 77, 77, 77);
        send_window(1'b0);
        get_beats(-1, 0, -1, 1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
